// File: rtl/commit_tracer.sv
// In-order trace serialiser for the dual-slot commit stream, with retire/cycle
// counters, sticky overflow/order flags and a no-commit hang watchdog.
module commit_tracer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CNTW    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0][63:0]      cmtpc,
  input  logic [1:0][6:0]       cmtaddr,
  input  logic [1:0][63:0]      cmtdata,
  output logic                  trc_vld,
  input  logic                  trc_rdy,
  output logic [63:0]           trc_pc,
  output logic [6:0]            trc_addr,
  output logic [63:0]           trc_data,
  output logic [CNTW-1:0]       instret,
  output logic [CNTW-1:0]       cycles,
  output logic [CNTW-1:0]       drops,
  output logic                  ovfl,
  output logic                  order_err,
  output logic                  hang
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [31:0] IDLE_LAST = (TIMEOUT == 0) ? 32'd0 : TIMEOUT - 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [6:0]  addr;
    logic [63:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        first, second, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, space;
  logic          v0, v1, pop;
  logic [1:0]    nin, pushed;
  logic [31:0]   idle;

  always_comb begin
    v0     = |cmtpc[0];
    v1     = |cmtpc[1];
    nin    = {1'b0, v0} + {1'b0, v1};
    // space is taken before this cycle's pop, so a pop never makes room for a push
    space  = (AW+1)'(DEPTH) - count;
    pushed = (space >= (AW+1)'(nin)) ? nin : space[1:0];
    first  = v0 ? entry_t'{cmtpc[0], cmtaddr[0], cmtdata[0]}
                : entry_t'{cmtpc[1], cmtaddr[1], cmtdata[1]};
    second = entry_t'{cmtpc[1], cmtaddr[1], cmtdata[1]};
    pop    = trc_vld && trc_rdy;
  end

  assign trc_vld  = (count != '0);
  assign head     = mem[rd_ptr];
  assign trc_pc   = trc_vld ? head.pc   : '0;
  assign trc_addr = trc_vld ? head.addr : '0;
  assign trc_data = trc_vld ? head.data : '0;

  always_ff @(posedge clk) begin
    if (pushed != 2'd0) mem[wr_ptr] <= first;
    if (pushed == 2'd2) mem[wr_ptr + AW'(1)] <= second;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      instret   <= '0;
      cycles    <= '0;
      drops     <= '0;
      ovfl      <= 1'b0;
      order_err <= 1'b0;
      hang      <= 1'b0;
      idle      <= '0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(pushed);
      rd_ptr  <= rd_ptr + AW'(pop);
      count   <= count + (AW+1)'(pushed) - (AW+1)'(pop);
      instret <= instret + CNTW'(nin);
      cycles  <= cycles + CNTW'(1);
      drops   <= drops + CNTW'(nin - pushed);
      if (nin != pushed) ovfl <= 1'b1;
      if (v1 && !v0) order_err <= 1'b1;
      if (nin != 2'd0) idle <= '0;
      else if (idle != '1) idle <= idle + 32'd1;
      if (TIMEOUT != 0 && nin == 2'd0 && idle == IDLE_LAST) hang <= 1'b1;
    end
  end

endmodule
